// File: rtl/mst_rr_arbiter.sv
// Round-robin arbiter for the shared pcie_tlp master port: one burst per grant,
// with a ready timeout and a per-grant word cap.
module mst_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int RDY_TMO   = 1024,
    parameter int MAX_WORDS = 256
) (
    input  logic                 pcie_clk,
    input  logic                 sys_rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      last_i,
    input  logic [NREQ*DW-1:0]   dat_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      st_o,
    output logic [NREQ-1:0]      ce_o,
    output logic                 mst_req_o,
    input  logic                 mst_rdy_i,
    input  logic                 mst_st_i,
    input  logic                 mst_ce_i,
    output logic [DW-1:0]        mst_dat_o,
    output logic [2:0]           owner_o,
    output logic                 busy_o,
    output logic                 err_tmo_o,
    output logic                 err_len_o
);

    // state | meaning
    // IDLE  | no owner; arbitrate from rr pointer on any req_i
    // REQ   | owner granted, mst_req_o high, waiting for mst_rdy_i
    // XFER  | burst running, words counted on mst_ce_i
    // GAP   | one dead cycle after a burst, pointer advances past owner
    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(RDY_TMO);
    localparam int WW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;

    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [IW-1:0]   own_inc;
    logic [NREQ-1:0] own_oh;
    logic            own_req;
    logic            own_last;
    logic            gnt_act;
    logic            tmo_hit;
    logic            len_hit;

    assign own_oh   = NREQ'(1) << own_q;
    assign own_req  = |(req_i & own_oh);
    assign own_last = |(last_i & own_oh);
    assign own_inc  = (int'(own_q) == NREQ - 1) ? '0 : own_q + 1'b1;

    // Withdraw takes precedence over timeout; ready takes precedence over both.
    assign tmo_hit = (state_q == REQ) && !mst_rdy_i && own_req && (tmr_q == '0);
    assign len_hit = (state_q == XFER) && mst_ce_i && !own_last && (wcnt_q == '0);

    // Scan downward so the last hit written is the one closest to the pointer.
    always_comb begin
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (req_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            tmr_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            tmr_q   <= tmr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        tmr_d   = tmr_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = REQ;
                    own_d   = pick_idx;
                    tmr_d   = TW'(RDY_TMO - 1);
                end
            end
            REQ: begin
                if (mst_rdy_i) begin
                    state_d = XFER;
                    wcnt_d  = WW'(MAX_WORDS - 1);
                end else if (!own_req) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    ptr_d   = own_inc;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            XFER: begin
                if (mst_ce_i) begin
                    if (own_last || (wcnt_q == '0)) begin
                        state_d = GAP;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
                ptr_d   = own_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_act   = (state_q == REQ) || (state_q == XFER);
        gnt_o     = gnt_act ? own_oh : '0;
        st_o      = (gnt_act && mst_st_i) ? own_oh : '0;
        ce_o      = (gnt_act && mst_ce_i) ? own_oh : '0;
        mst_dat_o = gnt_act ? dat_i[int'(own_q)*DW +: DW] : '0;
        mst_req_o = (state_q == REQ);
        busy_o    = (state_q != IDLE);
        owner_o   = 3'(own_q);
        err_tmo_o = tmo_hit;
        err_len_o = len_hit;
    end

endmodule

// File: tb/tb_mst_rr_arbiter.sv
// Directed bench for mst_rr_arbiter: vector table for a single burst plus
// sequences for reset abort, fairness, timeout, length cap and withdraw.
module tb_mst_rr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 16;
    localparam int RDY_TMO   = 16;
    localparam int MAX_WORDS = 8;
    localparam logic [63:0] D_BASE = 64'h4444_3333_2222_1111;

    logic              pcie_clk = 1'b0;
    logic              sys_rst  = 1'b1;
    logic [NREQ-1:0]   req_i    = '0;
    logic [NREQ-1:0]   last_i   = '0;
    logic [NREQ*DW-1:0] dat_i   = D_BASE;
    logic              mst_rdy_i = 1'b0;
    logic              mst_st_i  = 1'b0;
    logic              mst_ce_i  = 1'b0;
    logic [NREQ-1:0]   gnt_o, st_o, ce_o;
    logic              mst_req_o, busy_o, err_tmo_o, err_len_o;
    logic [DW-1:0]     mst_dat_o;
    logic [2:0]        owner_o;

    int n_cmp = 0;
    int n_err = 0;

    mst_rr_arbiter #(
        .NREQ(NREQ), .DW(DW), .RDY_TMO(RDY_TMO), .MAX_WORDS(MAX_WORDS)
    ) dut (
        .pcie_clk(pcie_clk), .sys_rst(sys_rst),
        .req_i(req_i), .last_i(last_i), .dat_i(dat_i),
        .gnt_o(gnt_o), .st_o(st_o), .ce_o(ce_o),
        .mst_req_o(mst_req_o), .mst_rdy_i(mst_rdy_i),
        .mst_st_i(mst_st_i), .mst_ce_i(mst_ce_i),
        .mst_dat_o(mst_dat_o), .owner_o(owner_o), .busy_o(busy_o),
        .err_tmo_o(err_tmo_o), .err_len_o(err_len_o)
    );

    always #4 pcie_clk = ~pcie_clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        rdy;
        logic        st;
        logic        ce;
        logic [15:0] d2;
        logic [34:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [34:0] mk(input logic [3:0] g, input logic [3:0] s,
                                       input logic [3:0] c, input logic rq, input logic bz,
                                       input logic [2:0] ow, input logic tm, input logic ln,
                                       input logic [15:0] d);
        return {g, s, c, rq, bz, ow, tm, ln, d};
    endfunction

    // Owner is only meaningful while busy, so it is masked otherwise.
    function automatic logic [34:0] cur_out();
        return {gnt_o, st_o, ce_o, mst_req_o, busy_o, (busy_o ? owner_o : 3'd0),
                err_tmo_o, err_len_o, mst_dat_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge pcie_clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] rq, input logic [3:0] lt, input logic rdy,
                       input logic st, input logic ce);
        req_i     = rq;
        last_i    = lt;
        mst_rdy_i = rdy;
        mst_st_i  = st;
        mst_ce_i  = ce;
    endtask

    task automatic do_reset();
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        nxt();
        nxt();
        sys_rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 40; k++) begin
            if (mst_req_o) break;
            nxt();
        end
        if (!mst_req_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no mst_req_o expected grant within 40 cycles", name);
        end
    endtask

    // Grant handshake then nw words; returns at the cycle after the last ce.
    task automatic burst(input int nw, input logic last_on_final,
                         output logic [2:0] own, output int len_at);
        wait_req("burst_req");
        own = owner_o;
        mst_rdy_i = 1'b1;
        nxt();
        mst_rdy_i = 1'b0;
        len_at = 0;
        for (int w = 1; w <= nw; w++) begin
            mst_ce_i = 1'b1;
            last_i   = (w == nw && last_on_final) ? 4'b1111 : 4'b0000;
            #1;
            if (err_len_o && len_at == 0) len_at = w;
            nxt();
        end
        mst_ce_i = 1'b0;
        last_i   = 4'b0000;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] own;
        int         la;
        int         tmo_at;

        // Single burst to requester 2; req_i drops during XFER and must be ignored.
        tbl.push_back('{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h2000, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000)});
        tbl.push_back('{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h2001, mk(4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2001)});
        tbl.push_back('{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h2002, mk(4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2002)});
        tbl.push_back('{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h2003, mk(4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2003)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 16'h2004, mk(4'h4, 4'h4, 4'h4, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2004)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h2005, mk(4'h4, 4'h0, 4'h4, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2005)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h2006, mk(4'h4, 4'h0, 4'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2006)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h2007, mk(4'h4, 4'h0, 4'h4, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2007)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h2008, mk(4'h4, 4'h0, 4'h4, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2008)});
        tbl.push_back('{4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 16'h2009, mk(4'h4, 4'h0, 4'h4, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h2009)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h200A, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h0000)});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h200B, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000)});

        repeat (3) @(negedge pcie_clk);
        #1;
        chk("reset_state", 64'(cur_out()), 64'(mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000)));
        sys_rst = 1'b0;

        foreach (tbl[i]) begin
            nxt();
            drv(tbl[i].req, tbl[i].last, tbl[i].rdy, tbl[i].st, tbl[i].ce);
            dat_i[47:32] = tbl[i].d2;
            #1;
            chk($sformatf("single_v%0d", i), 64'(cur_out()), 64'(tbl[i].exp));
        end
        dat_i = D_BASE;

        // Reset mid-XFER; pointer (3 before reset) must return to 0.
        nxt();
        drv(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
        wait_req("rst_pre_req");
        chk("rst_pre_owner", 64'(owner_o), 64'd3);
        mst_rdy_i = 1'b1;
        nxt();
        drv(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_pre_xfer", 64'({gnt_o, ce_o, busy_o}), 64'({4'b1000, 4'b1000, 1'b1}));
        sys_rst = 1'b1;
        nxt();
        chk("rst_abort", 64'(cur_out()), 64'd0);
        nxt();
        nxt();
        sys_rst = 1'b0;
        drv(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_release", 64'(cur_out()), 64'd0);
        nxt();
        wait_req("rst_ptr_req");
        chk("rst_ptr0", 64'(owner_o), 64'd0);

        // Fairness: everyone requesting, 2-word bursts.
        do_reset();
        req_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            burst(2, 1'b1, own, la);
            chk($sformatf("fair_owner%0d", i), 64'(own), 64'(i % 4));
        end

        // Timeout: owner 1 never sees ready; next grant goes to 2.
        do_reset();
        drv(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0);
        wait_req("tmo_req");
        chk("tmo_owner", 64'(owner_o), 64'd1);
        tmo_at = 0;
        for (int k = 1; k <= 24; k++) begin
            if (err_tmo_o) begin
                tmo_at = k;
                break;
            end
            nxt();
        end
        chk("tmo_cycle", 64'(tmo_at), 64'd16);
        nxt();
        chk("tmo_idle", 64'(cur_out()), 64'd0);
        nxt();
        chk("tmo_next_grant", 64'(cur_out()), 64'(mk(4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 16'h3333)));

        // Length cap: 8 words without last.
        do_reset();
        req_i = 4'b0001;
        burst(8, 1'b0, own, la);
        chk("len_at", 64'(la), 64'd8);
        req_i = 4'b0000;
        #1;
        chk("len_gap", 64'(cur_out()), 64'(mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 16'h0000)));
        nxt();
        chk("len_idle", 64'(cur_out()), 64'd0);
        req_i = 4'b0001;
        burst(8, 1'b1, own, la);
        chk("len_last_same_cycle", 64'(la), 64'd0);
        req_i = 4'b0000;
        #1;
        chk("len_last_gap", 64'({busy_o, gnt_o, err_len_o}), 64'({1'b1, 4'b0000, 1'b0}));

        // Withdraw in REQ, then re-raise.
        do_reset();
        req_i = 4'b1000;
        wait_req("wd_req");
        chk("wd_owner", 64'(owner_o), 64'd3);
        req_i = 4'b0000;
        nxt();
        chk("wd_idle", 64'(cur_out()), 64'd0);
        req_i = 4'b1000;
        wait_req("wd_rereq");
        chk("wd_regrant", 64'(owner_o), 64'd3);

        // Withdraw must not move the pointer past the withdrawn owner.
        do_reset();
        req_i = 4'b0100;
        wait_req("wd2_req");
        req_i = 4'b0000;
        nxt();
        req_i = 4'b1111;
        wait_req("wd2_rereq");
        chk("wd_ptr_kept", 64'(owner_o), 64'd0);
        drv(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        nxt();
        chk("rdy_beats_wd", 64'({gnt_o, busy_o, mst_req_o}), 64'({4'b0001, 1'b1, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
